err_diffuse_quantizer: RTL and testbench

ERR_DIFFUSE_QUANTIZER -- requirements
Module: err_diffuse_quantizer

---
 rtl/err_diffuse_pkg.sv | 18 +
 rtl/err_line_ram.sv | 24 ++
 rtl/err_diffuse_quantizer.sv | 172 +++++++++++++++++
 tb/tb_err_diffuse_quantizer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_diffuse_pkg.sv
// Shared types and diffusion weights for the error-diffusion quantizer.
// Weights are in 16ths: right 7, below-left 3, below 5, below-right 1.
package err_diffuse_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_FS     = 2'd1,
    MODE_1D     = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int FS_W_RIGHT = 7;
  localparam int FS_W_BL    = 3;
  localparam int FS_W_B     = 5;
  localparam int FS_W_BR    = 1;
  localparam int FS_SHIFT   = 4;

endpackage

// File: rtl/err_line_ram.sv
// Error accumulator line buffer: simple dual-port, registered 1-cycle read, no reset.
// Contents are don't-care at frame start; the reader masks row 0.
module err_line_ram #(
  parameter int DEPTH = 320,
  parameter int DW    = 14,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdat_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdat_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdat_i;
    if (re_i) rdat_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/err_diffuse_quantizer.sv
// Streaming grey-to-N-level quantizer with threshold, Floyd-Steinberg or 1-D error diffusion.
// Fixed 3-cycle latency, one pixel per cycle, no backpressure (strobe in, strobe out).
module err_diffuse_quantizer
  import err_diffuse_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int OUT_BITS = 1,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [1:0]          mode_in,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic                valid_in,
  output logic [OUT_BITS-1:0] code_out,
  output logic [10:0]         hcount_out,
  output logic [9:0]          vcount_out,
  output logic                valid_out
);

  localparam int ACC_W = PIX_W + 6;
  localparam int ERR_W = PIX_W + 1;
  localparam int CW    = ACC_W + 2;
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [10:0]          H_LIM  = 11'(IMG_W);
  localparam logic [10:0]          H_LAST = 11'(IMG_W - 1);
  localparam logic [9:0]           V_LIM  = 10'(IMG_H);
  localparam logic [AW-1:0]        A_LAST = AW'(IMG_W - 1);
  localparam logic signed [CW-1:0] C_MAX  = CW'((2 ** PIX_W) - 1);

  function automatic logic [PIX_W-1:0] replicate(input logic [OUT_BITS-1:0] c);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_W; i++) r[PIX_W-1-i] = c[OUT_BITS-1-(i % OUT_BITS)];
    return r;
  endfunction

  logic                    in_ok;
  mode_e                   mode_new, mode_d, mode_q;
  logic                    s1_vld_q, s2_vld_q, out_vld_q;
  logic [PIX_W-1:0]        s1_pix_q;
  logic [10:0]             s1_h_q, s2_h_q, out_h_q;
  logic [9:0]              s1_v_q, s2_v_q, out_v_q;
  mode_e                   s1_mode_q;
  logic [OUT_BITS-1:0]     s2_code_q, out_code_q;
  logic                    ram_we, ram_re;
  logic [AW-1:0]           ram_waddr;
  logic [ACC_W-1:0]        ram_wdat, ram_rdat;
  logic signed [ERR_W-1:0] e_left_q, e_left2_q, e_m1, e_m2, err;
  logic signed [ACC_W-1:0] above, below_sum, flush_sum;
  logic signed [CW-1:0]    fs_sum, c_full;
  logic [PIX_W-1:0]        c_clamp, recon;
  logic [OUT_BITS-1:0]     code;
  logic                    fs_wr, flush_d, flush_q;
  logic [ACC_W-1:0]        flush_dat_q;

  // Mode only changes on the first pixel of a frame; reserved falls back to threshold.
  always_comb begin
    in_ok    = valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
    mode_new = (mode_e'(mode_in) == MODE_RSVD) ? MODE_THRESH : mode_e'(mode_in);
    mode_d   = (in_ok && hcount_in == '0 && vcount_in == '0) ? mode_new : mode_q;
    ram_re   = in_ok && (mode_d == MODE_FS);
  end

  err_line_ram #(.DEPTH(IMG_W), .DW(ACC_W)) u_line_ram (
    .clk_i   (clk_in),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdat_i  (ram_wdat),
    .re_i    (ram_re),
    .raddr_i (hcount_in[AW-1:0]),
    .rdat_o  (ram_rdat)
  );

  always_comb begin
    e_m1   = (s1_h_q == '0) ? '0 : e_left_q;
    e_m2   = (s1_h_q < 11'd2) ? '0 : e_left2_q;
    above  = (s1_v_q == '0 || s1_mode_q != MODE_FS) ? '0 : $signed(ram_rdat);
    fs_sum = CW'(above) + CW'(e_m1) * CW'(FS_W_RIGHT);
    case (s1_mode_q)
      MODE_FS: c_full = CW'($signed({1'b0, s1_pix_q})) + (fs_sum >>> FS_SHIFT);
      MODE_1D: c_full = CW'($signed({1'b0, s1_pix_q})) + CW'(e_m1);
      default: c_full = CW'($signed({1'b0, s1_pix_q}));
    endcase
    if (c_full[CW-1])        c_clamp = '0;
    else if (c_full > C_MAX) c_clamp = '1;
    else                     c_clamp = c_full[PIX_W-1:0];
    code      = c_clamp[PIX_W-1 -: OUT_BITS];
    recon     = replicate(code);
    err       = $signed({1'b0, c_clamp}) - $signed({1'b0, recon});
    below_sum = ACC_W'(e_m2) * ACC_W'(FS_W_BR) + ACC_W'(e_m1) * ACC_W'(FS_W_B)
              + ACC_W'(err) * ACC_W'(FS_W_BL);
    flush_sum = ACC_W'(e_m1) * ACC_W'(FS_W_BR) + ACC_W'(err) * ACC_W'(FS_W_B);
    fs_wr     = s1_vld_q && (s1_mode_q == MODE_FS);
    flush_d   = fs_wr && (s1_h_q == H_LAST);
  end

  // Pixel x completes acc[x-1]; the row-end flush lands while x=0 of the next row writes nothing.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdat  = '0;
    if (flush_q) begin
      ram_we    = 1'b1;
      ram_waddr = A_LAST;
      ram_wdat  = flush_dat_q;
    end else if (fs_wr && s1_h_q != '0) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(s1_h_q - 11'd1);
      ram_wdat  = below_sum;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q      <= MODE_THRESH;
      s1_vld_q    <= 1'b0;
      s1_pix_q    <= '0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_mode_q   <= MODE_THRESH;
      e_left_q    <= '0;
      e_left2_q   <= '0;
      flush_q     <= 1'b0;
      flush_dat_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_code_q   <= '0;
      s2_h_q      <= '0;
      s2_v_q      <= '0;
      out_vld_q   <= 1'b0;
      out_code_q  <= '0;
      out_h_q     <= '0;
      out_v_q     <= '0;
    end else begin
      mode_q   <= mode_d;
      s1_vld_q <= in_ok;
      if (in_ok) begin
        s1_pix_q  <= pixel_in;
        s1_h_q    <= hcount_in;
        s1_v_q    <= vcount_in;
        s1_mode_q <= mode_d;
      end
      if (s1_vld_q) begin
        e_left_q  <= err;
        e_left2_q <= e_m1;
      end
      flush_q     <= flush_d;
      flush_dat_q <= flush_sum;
      s2_vld_q    <= s1_vld_q;
      if (s1_vld_q) begin
        s2_code_q <= code;
        s2_h_q    <= s1_h_q;
        s2_v_q    <= s1_v_q;
      end
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_code_q <= s2_code_q;
        out_h_q    <= s2_h_q;
        out_v_q    <= s2_v_q;
      end
    end
  end

  assign valid_out  = out_vld_q;
  assign code_out   = out_code_q;
  assign hcount_out = out_h_q;
  assign vcount_out = out_v_q;

endmodule

// File: tb/tb_err_diffuse_quantizer.sv
// Self-checking bench for err_diffuse_quantizer on a 4x3 image, 8-bit in, 1-bit out.
// A frame-level reference model predicts each output and its arrival cycle.
module tb_err_diffuse_quantizer;

  localparam int PIX_W    = 8;
  localparam int OUT_BITS = 1;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;

  logic                clk_in    = 1'b0;
  logic                rst_in    = 1'b0;
  logic [1:0]          mode_in   = 2'd0;
  logic [PIX_W-1:0]    pixel_in  = '0;
  logic [10:0]         hcount_in = '0;
  logic [9:0]          vcount_in = '0;
  logic                valid_in  = 1'b0;
  logic [OUT_BITS-1:0] code_out;
  logic [10:0]         hcount_out;
  logic [9:0]          vcount_out;
  logic                valid_out;

  typedef struct {
    int code;
    int h;
    int v;
    int cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int m_mode = 0;
  int m_eprev = 0;
  int m_erow[IMG_W];
  int m_acc[IMG_W];

  err_diffuse_quantizer #(
    .PIX_W(PIX_W), .OUT_BITS(OUT_BITS), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .mode_in    (mode_in),
    .pixel_in   (pixel_in),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .valid_in   (valid_in),
    .code_out   (code_out),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .valid_out  (valid_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    rec_t r;
    #1;
    if (valid_out === 1'b1) begin
      r.code = int'(code_out);
      r.h    = int'(hcount_out);
      r.v    = int'(vcount_out);
      r.cyc  = cyc;
      obs_q.push_back(r);
    end
  end

  // Reference: whole-row error bookkeeping, below-row accumulators rebuilt at row end.
  task automatic model_push(input int p, input int h, input int v);
    int   above, el, c, code, e;
    rec_t r;
    if (h >= IMG_W || v >= IMG_H) return;
    if (h == 0 && v == 0) m_mode = (mode_in == 2'd3) ? 0 : int'(mode_in);
    el    = (h == 0) ? 0 : m_eprev;
    above = (v == 0) ? 0 : m_acc[h];
    case (m_mode)
      1:       c = p + ((above + 7 * el) >>> 4);
      2:       c = p + el;
      default: c = p;
    endcase
    if (c < 0) c = 0;
    if (c > 255) c = 255;
    code = c >> (PIX_W - OUT_BITS);
    e = c - (code * 255);
    m_eprev   = e;
    m_erow[h] = e;
    if (m_mode == 1 && h == IMG_W - 1)
      for (int x = 0; x < IMG_W; x++)
        m_acc[x] = ((x > 0) ? m_erow[x-1] : 0) + 5 * m_erow[x]
                 + ((x < IMG_W - 1) ? 3 * m_erow[x+1] : 0);
    r.code = code; r.h = h; r.v = v; r.cyc = cyc + 3;
    exp_q.push_back(r);
  endtask

  task automatic drive(input int p, input int h, input int v);
    @(negedge clk_in);
    pixel_in  = 8'(p);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    valid_in  = 1'b1;
    model_push(p, h, v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
  endtask

  task automatic drive_rows(input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = 0; h < IMG_W; h++) begin
        drive(int'($urandom_range(0, 255)), h, v);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
  endtask

  task automatic test_reset();
    rst_in  = 1'b0;
    mode_in = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      valid_in = 1'b1; pixel_in = 8'(200 + i); hcount_in = 11'(i % 2); vcount_in = '0;
      @(posedge clk_in); #1;
      checks++;
      if (valid_out !== 1'b0 || code_out !== '0 || hcount_out !== '0 || vcount_out !== '0) begin
        errors++;
        $display("FAIL reset_out: valid=%0b code=%0d h=%0d v=%0d, required all 0",
                 valid_out, code_out, hcount_out, vcount_out);
      end
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    rst_in   = 1'b1;
    repeat (6) @(negedge clk_in);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release: %0d outputs after release, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_threshold();
    rec_t e, o;
    int   n = 0;
    mode_in = 2'd0;
    drive(127, 0, 0);
    drive(128, 1, 0);
    drive(200, 4, 0);
    drive(60, 2, 0);
    drive(10, 3, 0);
    idle(2);
    drive_rows(1, 2);
    drive(90, 0, 3);
    idle(1);
    mode_in = 2'd3;
    drive_rows(0, 2);
    idle(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL thr_missing: no output, required code=%0d at (%0d,%0d)", e.code, e.h, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.h !== e.h || o.v !== e.v || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL thr_out: got code=%0d (%0d,%0d) cyc %0d, required code=%0d (%0d,%0d) cyc %0d",
                   o.code, o.h, o.v, o.cyc, e.code, e.h, e.v, e.cyc);
        end
        if (n < 2) begin
          checks++;
          if (o.code !== n) begin
            errors++;
            $display("FAIL thr_127_128: pixel %0d got code=%0d, required %0d", 127 + n, o.code, n);
          end
        end
      end
      n++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL thr_extra: %0d unexpected outputs, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fs();
    rec_t e, o;
    int   n = 0;
    int   fs_ref[5] = '{1, 0, 1, 0, 0};
    mode_in = 2'd1;
    for (int h = 0; h < IMG_W; h++) drive(128, h, 0);
    drive(128, 0, 1);
    for (int h = 1; h < IMG_W; h++) drive(int'($urandom_range(0, 255)), h, 1);
    idle(1);
    drive_rows(2, 2);
    idle(2);
    mode_in = 2'd2;
    drive(100, 0, 0);
    drive(255, 1, 0);
    drive(200, 2, 0);
    drive(10, 3, 0);
    drive_rows(1, 2);
    idle(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL fs_missing: no output, required code=%0d at (%0d,%0d)", e.code, e.h, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.h !== e.h || o.v !== e.v || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL fs_out: got code=%0d (%0d,%0d) cyc %0d, required code=%0d (%0d,%0d) cyc %0d",
                   o.code, o.h, o.v, o.cyc, e.code, e.h, e.v, e.cyc);
        end
        if (n < 5) begin
          checks++;
          if (o.code !== fs_ref[n]) begin
            errors++;
            $display("FAIL fs_known_%0d: got code=%0d, required %0d", n, o.code, fs_ref[n]);
          end
        end
      end
      n++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL fs_extra: %0d unexpected outputs, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_mode_switch();
    rec_t e, o;
    mode_in = 2'd1;
    drive_rows(0, 0);
    mode_in = 2'd0;
    drive_rows(1, 2);
    drive_rows(0, 1);
    idle(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL mode_missing: no output, required code=%0d at (%0d,%0d)", e.code, e.h, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.h !== e.h || o.v !== e.v || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL mode_out: got code=%0d (%0d,%0d) cyc %0d, required code=%0d (%0d,%0d) cyc %0d",
                   o.code, o.h, o.v, o.cyc, e.code, e.h, e.v, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL mode_extra: %0d unexpected outputs, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    rec_t e, o;
    int   n = 0;
    mode_in = 2'd1;
    drive_rows(0, 0);
    idle(1);
    drive(int'($urandom_range(0, 255)), 0, 1);
    drive(int'($urandom_range(0, 255)), 1, 1);
    @(negedge clk_in);
    valid_in = 1'b0;
    rst_in   = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    m_eprev = 0;
    m_mode  = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    idle(3);
    drive(200, 0, 0);
    for (int h = 1; h < IMG_W; h++) drive(int'($urandom_range(0, 255)), h, 0);
    drive_rows(1, 2);
    idle(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rstmid_missing: no output, required code=%0d at (%0d,%0d)", e.code, e.h, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.h !== e.h || o.v !== e.v || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL rstmid_out: got code=%0d (%0d,%0d) cyc %0d, required code=%0d (%0d,%0d) cyc %0d",
                   o.code, o.h, o.v, o.cyc, e.code, e.h, e.v, e.cyc);
        end
        if (n == IMG_W) begin
          checks++;
          if (o.code !== 1 || o.h !== 0 || o.v !== 0) begin
            errors++;
            $display("FAIL rstmid_restart: got code=%0d at (%0d,%0d), required code=1 at (0,0)",
                     o.code, o.h, o.v);
          end
        end
      end
      n++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_extra: %0d unexpected outputs, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_fs();
    test_mode_switch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
